// File: rtl/matrix_3x3_gen.sv
// Sliding 3x3 window generator: two line buffers plus a 3-tap shift per row,
// fixed 2-clock latency from gray_* to matrix_*, with row/column edge masking.
module matrix_3x3_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic       video_clk,
    input  logic       rst,
    input  logic       gray_vs,
    input  logic       gray_de,
    input  logic [7:0] gray_data,
    output logic       matrix_vs,
    output logic       matrix_de,
    output logic [7:0] matrix11,
    output logic [7:0] matrix12,
    output logic [7:0] matrix13,
    output logic [7:0] matrix21,
    output logic [7:0] matrix22,
    output logic [7:0] matrix23,
    output logic [7:0] matrix31,
    output logic [7:0] matrix32,
    output logic [7:0] matrix33
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_ACTIVE - 1);

    logic              vs_d, de_d;
    logic [ADDR_W-1:0] col_cnt;
    logic [1:0]        line_cnt;
    logic              ovf;

    logic              vs_rise, de_fall, wr_en;
    logic [ADDR_W-1:0] cur_col;
    logic [1:0]        cur_line;
    logic              cur_ovf;

    logic [7:0]        lb0 [H_ACTIVE];
    logic [7:0]        lb1 [H_ACTIVE];

    logic              vs1, de1, ovf1;
    logic [ADDR_W-1:0] col1;
    logic [1:0]        line1;
    logic [7:0]        pix1, rd0, rd1;

    logic [7:0]        sh [3][3];
    logic [7:0]        nx [3][3];
    logic [7:0]        ms [3][3];
    logic [7:0]        mo [3][3];
    logic [2:0]        row_en;

    // A frame-start edge clears position before the coincident pixel is used.
    always_comb begin
        vs_rise  = gray_vs & ~vs_d;
        de_fall  = ~gray_de & de_d;
        cur_col  = vs_rise ? '0 : col_cnt;
        cur_line = vs_rise ? 2'd0 : line_cnt;
        cur_ovf  = vs_rise ? 1'b0 : ovf;
        wr_en    = gray_de & ~cur_ovf;
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            vs_d     <= 1'b0;
            de_d     <= 1'b0;
            col_cnt  <= '0;
            line_cnt <= 2'd0;
            ovf      <= 1'b0;
        end else begin
            vs_d <= gray_vs;
            de_d <= gray_de;
            if (gray_de) begin
                col_cnt  <= (cur_col == COL_LAST) ? cur_col : cur_col + ADDR_W'(1);
                ovf      <= cur_ovf | (cur_col == COL_LAST);
                line_cnt <= cur_line;
            end else begin
                if (vs_rise || de_fall) begin
                    col_cnt <= '0;
                    ovf     <= 1'b0;
                end
                if (vs_rise)
                    line_cnt <= 2'd0;
                else if (de_fall && line_cnt != 2'd2)
                    line_cnt <= line_cnt + 2'd1;
            end
        end
    end

    // Line buffers: read-before-write, contents deliberately not reset.
    always_ff @(posedge video_clk) begin
        if (wr_en) begin
            lb0[cur_col] <= gray_data;
            lb1[cur_col] <= lb0[cur_col];
        end
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            vs1   <= 1'b0;
            de1   <= 1'b0;
            ovf1  <= 1'b0;
            col1  <= '0;
            line1 <= 2'd0;
            pix1  <= 8'd0;
            rd0   <= 8'd0;
            rd1   <= 8'd0;
        end else begin
            vs1 <= gray_vs;
            de1 <= gray_de;
            if (gray_de) begin
                ovf1  <= cur_ovf;
                col1  <= cur_col;
                line1 <= cur_line;
                pix1  <= gray_data;
                rd0   <= lb0[cur_col];
                rd1   <= lb1[cur_col];
            end
        end
    end

    // Shift the raw window, then mask rows/columns that have no valid source.
    always_comb begin
        nx     = sh;
        row_en = {1'b1, (line1 != 2'd0) & ~ovf1, (line1 == 2'd2) & ~ovf1};
        if (de1) begin
            for (int i = 0; i < 3; i++) begin
                nx[i][0] = sh[i][1];
                nx[i][1] = sh[i][2];
            end
            nx[0][2] = rd1;
            nx[1][2] = rd0;
            nx[2][2] = pix1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ms[i][j] = nx[i][j];
                if (!row_en[i])
                    ms[i][j] = 8'd0;
                if (j == 0 && col1 < ADDR_W'(2))
                    ms[i][j] = 8'd0;
                if (j == 1 && col1 == '0)
                    ms[i][j] = 8'd0;
            end
        end
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            matrix_vs <= 1'b0;
            matrix_de <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    sh[i][j] <= 8'd0;
                    mo[i][j] <= 8'd0;
                end
            end
        end else begin
            matrix_vs <= vs1;
            matrix_de <= de1;
            if (de1) begin
                sh <= nx;
                mo <= ms;
            end
        end
    end

    assign matrix11 = mo[0][0];
    assign matrix12 = mo[0][1];
    assign matrix13 = mo[0][2];
    assign matrix21 = mo[1][0];
    assign matrix22 = mo[1][1];
    assign matrix23 = mo[1][2];
    assign matrix31 = mo[2][0];
    assign matrix32 = mo[2][1];
    assign matrix33 = mo[2][2];

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: frame-image reference model with a 2-cycle
// expectation pipeline, plus literal spot checks on known pixel patterns.
module tb_matrix_3x3_gen;

    localparam int unsigned H = 8;

    logic       clk = 1'b0;
    logic       rst, vs, de;
    logic [7:0] data;
    logic       m_vs, m_de;
    logic [7:0] m11, m12, m13, m21, m22, m23, m31, m32, m33;

    matrix_3x3_gen #(.H_ACTIVE(H), .ADDR_W(3)) dut (
        .video_clk(clk), .rst(rst), .gray_vs(vs), .gray_de(de), .gray_data(data),
        .matrix_vs(m_vs), .matrix_de(m_de),
        .matrix11(m11), .matrix12(m12), .matrix13(m13),
        .matrix21(m21), .matrix22(m22), .matrix23(m23),
        .matrix31(m31), .matrix32(m32), .matrix33(m33)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic        de;
        logic [71:0] win;
        int          r;
        int          c;
    } exp_t;

    exp_t        pipe[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  img [16][16];
    int          mr, mc;
    logic        m_vs_d, m_de_d;
    logic [71:0] m_win;
    bit          lit;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {m11, m12, m13, m21, m22, m23, m31, m32, m33};
    endfunction

    task automatic model_reset();
        exp_t z;
        mr = 0; mc = 0; m_vs_d = 1'b0; m_de_d = 1'b0; m_win = '0;
        z.vs = 1'b0; z.de = 1'b0; z.win = '0; z.r = -1; z.c = -1;
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endtask

    // Window for pixel (r,c): rows r-2..r, cols c-2..c; missing sources read 0,
    // and past the line-buffer depth only the current row survives.
    function automatic logic [71:0] ref_window(input int r, input int c);
        logic [71:0] w = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                int sr = r - 2 + k;
                int cc = c - 2 + j;
                int idx = 3 * k + j;
                if (cc >= 0 && sr >= 0 && (k == 2 || c < int'(H)))
                    w[71 - 8 * idx -: 8] = img[(sr > 15) ? 15 : sr][cc];
            end
        end
        return w;
    endfunction

    task automatic step(input logic v, input logic d, input logic [7:0] x);
        exp_t e, n;
        bit   vr, df;
        @(negedge clk);
        e = pipe.pop_front();
        check("matrix_vs", 72'(m_vs), 72'(e.vs));
        check("matrix_de", 72'(m_de), 72'(e.de));
        check("window", dut_win(), e.win);
        if (lit && e.de) begin
            if (e.r == 2 && e.c == 2) check("pix_2_2", dut_win(), 72'h000102_101112_202122);
            if (e.r == 1 && e.c == 3) check("pix_1_3", dut_win(), 72'h000000_010203_111213);
            if (e.r == 3 && e.c == 0) check("pix_3_0", dut_win(), 72'h000010_000020_000030);
            if (e.r == 0 && e.c == 5) check("pix_0_5", dut_win(), 72'h000000_000000_030405);
            if (e.r == 2 && e.c == 8) check("pix_2_8", dut_win(), 72'h000000_000000_262728);
            if (e.r == 2 && e.c == 9) check("pix_2_9", dut_win(), 72'h000000_000000_272829);
        end
        vs = v; de = d; data = x;
        vr = v && !m_vs_d;
        df = !d && m_de_d;
        n.r = -1; n.c = -1;
        if (vr) begin mr = 0; mc = 0; end
        if (d) begin
            img[(mr > 15) ? 15 : mr][mc] = x;
            m_win = ref_window(mr, mc);
            n.r = mr; n.c = mc;
            mc++;
        end else if (df && !vr) begin
            mr++; mc = 0;
        end
        n.vs = v; n.de = d; n.win = m_win;
        pipe.push_back(n);
        m_vs_d = v; m_de_d = d;
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        rst = 1'b1; vs = 1'b0; de = 1'b0; data = 8'd0;
        #1;
        check("rst_async", {62'd0, m_vs, m_de, dut_win()[7:0]}, 72'd0);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check("rst_win", dut_win(), 72'd0);
            check("rst_ctl", 72'({m_vs, m_de}), 72'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // rows lines of len pixels; long_row gets 10; abort_row stops after col 4.
    task automatic send_frame(input int rows, input int len, input int long_row,
                              input bit coincident, input bit rnd, input int abort_row);
        if (!coincident) begin
            step(1'b1, 1'b0, 8'd0);
            step(1'b1, 1'b0, 8'd0);
            step(1'b0, 1'b0, 8'd0);
        end
        for (int r = 0; r < rows; r++) begin
            int l = (r == long_row) ? 10 : len;
            for (int c = 0; c < l; c++) begin
                logic [7:0] px = rnd ? 8'($urandom) : 8'(r * 16 + c);
                step(coincident && r == 0 && c < 2, 1'b1, px);
                if (r == abort_row && c == 4) return;
            end
            for (int g = 0, n = rnd ? int'($urandom_range(2, 5)) : 4; g < n; g++)
                step(1'b0, 1'b0, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b1; vs = 1'b0; de = 1'b0; data = 8'd0; lit = 1'b1;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                img[i][j] = 8'd0;
        model_reset();
        do_reset(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);

        // mid-stream reset, then idle outputs must stay zero
        for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 8'(c));
        do_reset(3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);

        send_frame(4, 8, -1, 1'b0, 1'b0, -1);
        send_frame(4, 8, -1, 1'b1, 1'b0, -1);
        send_frame(4, 8, 2, 1'b0, 1'b0, -1);
        send_frame(4, 8, -1, 1'b0, 1'b0, 2);
        do_reset(3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0);
        // pixels before any frame sync count as line 0
        for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 8'(c));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);
        send_frame(4, 8, -1, 1'b0, 1'b0, -1);

        lit = 1'b0;
        for (int f = 0; f < 4; f++)
            send_frame(int'($urandom_range(3, 6)), int'($urandom_range(3, 10)), -1,
                       1'($urandom_range(0, 1)), 1'b1, -1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
